rk2040_irq_ctrl: RTL

Interrupt controller for the RK2040 core. It watches up to eight external input lines (normally `inputPort[7:0]`), detects the configured edge on each, and latches pending flags. It presents one prioritised request at a time to the core's interrupt entry logic through a request/acknowledge/return handshake. It is the receiving end of the falling-edge interrupt stimulus the top-level benches drive on `inputPort[5]`.

---
 rtl/rk2040_irq_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rk2040_irq_ctrl.sv
// rtl/rk2040_irq_ctrl.sv - edge-triggered, fixed-priority interrupt controller with req/ack/ret handshake
// Optional two-flop input synchronizer: define RK2040_IRQ_SYNC_EN.
module rk2040_irq_ctrl #(
    parameter int         NUM_IRQ   = 8,
    parameter logic [7:0] POL_RESET = 8'h00,
    parameter logic [7:0] EN_RESET  = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [NUM_IRQ-1:0] cfg_wdata,
    output logic [NUM_IRQ-1:0] cfg_rdata,
    output logic               irq_req,
    output logic [2:0]         irq_id,
    input  logic               irq_ack,
    input  logic               irq_ret,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending
);

    typedef enum logic [1:0] {
        sIdle,
        sReq,
        sService
    } ctrlState_t;

    ctrlState_t         state;
    ctrlState_t         stateNext;
    logic               loadId;
    logic [2:0]         winnerId;
    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] polarity;
    logic [NUM_IRQ-1:0] lineSync;
    logic [NUM_IRQ-1:0] linePrev;
    logic [NUM_IRQ-1:0] edgeHit;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] idMask;
    logic [NUM_IRQ-1:0] pendingNext;
    logic               reqLive;
    logic               ackTaken;

`ifdef RK2040_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] syncMeta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            syncMeta <= '0;
            lineSync <= '0;
        end else begin
            syncMeta <= irq_in;
            lineSync <= syncMeta;
        end
    end
`else
    // Inputs are already synchronous to clk; one sampling flop suffices.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lineSync <= '0;
        end else begin
            lineSync <= irq_in;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            linePrev <= '0;
        end else begin
            linePrev <= lineSync;
        end
    end

    assign edgeHit  = (polarity & lineSync & ~linePrev) | (~polarity & ~lineSync & linePrev);
    assign eligible = pending & enable;
    assign ackTaken = (state == sReq) && irq_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable   <= EN_RESET[NUM_IRQ-1:0];
            polarity <= POL_RESET[NUM_IRQ-1:0];
        end else if (cfg_we) begin
            if (cfg_addr == 2'd0) begin
                enable <= cfg_wdata;
            end
            if (cfg_addr == 2'd1) begin
                polarity <= cfg_wdata;
            end
        end
    end

    always_comb begin
        idMask = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            idMask[i] = (irq_id == 3'(i));
        end
    end

    assign reqLive = |(idMask & pending & enable);

    always_comb begin
        winnerId = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winnerId = 3'(i);
            end
        end
    end

    // Clears first, sets last: a fresh hardware edge always survives an ack or W1C.
    always_comb begin
        pendingNext = pending;
        if (cfg_we && cfg_addr == 2'd2) begin
            pendingNext = pendingNext & ~cfg_wdata;
        end
        if (ackTaken) begin
            pendingNext = pendingNext & ~idMask;
        end
        if (cfg_we && cfg_addr == 2'd3) begin
            pendingNext = pendingNext | cfg_wdata;
        end
        pendingNext = pendingNext | edgeHit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pendingNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= sIdle;
        end else begin
            state <= stateNext;
        end
    end

    // An ack seen while the request is visible is honoured even if the line is withdrawn that cycle.
    always_comb begin
        stateNext = state;
        loadId    = 1'b0;
        case (state)
            sIdle: begin
                if (|eligible) begin
                    stateNext = sReq;
                    loadId    = 1'b1;
                end
            end
            sReq: begin
                if (irq_ack) begin
                    stateNext = sService;
                end else if (!reqLive) begin
                    stateNext = sIdle;
                end
            end
            sService: begin
                if (irq_ret) begin
                    stateNext = sIdle;
                end
            end
            default: stateNext = sIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_id <= '0;
        end else if (loadId) begin
            irq_id <= winnerId;
        end
    end

    assign irq_req    = (state == sReq);
    assign in_service = (state == sService);

    always_comb begin
        cfg_rdata = pending;
        case (cfg_addr)
            2'd0:    cfg_rdata = enable;
            2'd1:    cfg_rdata = polarity;
            default: cfg_rdata = pending;
        endcase
    end

endmodule
